// File: rtl/adder_port_arbiter.sv
// adder_port_arbiter: round-robin arbiter sharing one WIDTH-bit adder between requesters A and B, with a registered valid/ready result
module adder_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_reqA_valid,
  input  logic [WIDTH-1:0] i_reqA_opA,
  input  logic [WIDTH-1:0] i_reqA_opB,
  output logic             o_reqA_ready,
  input  logic             i_reqB_valid,
  input  logic [WIDTH-1:0] i_reqB_opA,
  input  logic [WIDTH-1:0] i_reqB_opB,
  output logic             o_reqB_ready,
  output logic             o_select,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_carry,
  output logic             o_res_id,
  input  logic             i_res_ready,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic id, last_grant, grant_b, accept;
  always_comb begin
    grant_b = i_reqB_valid && (!i_reqA_valid || !last_grant);
    o_reqA_ready = (state == IDLE) && i_reqA_valid && !grant_b;
    o_reqB_ready = (state == IDLE) && grant_b;
    accept = o_reqA_ready || o_reqB_ready;
    o_busy = state != IDLE;
    state_nx = state == IDLE    ? (accept ? COMPUTE : IDLE) :
               state == COMPUTE ? RESP :
               (i_res_ready ? IDLE : RESP);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      o_select <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      id <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_data <= '0;
      o_res_carry <= 1'b0;
      o_res_id <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= grant_b ? i_reqB_opA : i_reqA_opA;
        op_b <= grant_b ? i_reqB_opB : i_reqA_opB;
        id <= grant_b;
        o_select <= grant_b;
        last_grant <= grant_b;
      end
      if (state == COMPUTE) begin
        {o_res_carry, o_res_data} <= {1'b0, op_a} + {1'b0, op_b};
        o_res_id <= id;
        o_res_valid <= 1'b1;
      end
      if (state == RESP && i_res_ready) o_res_valid <= 1'b0;
    end
  end
endmodule
